avr_dmem_arbiter: RTL and testbench
===================================

# avr_dmem_arbiter

Single-port data-memory arbiter between the AVR core data port and an auxiliary master (debug/loader/DMA). Sits between `avr_cpu` (data address, write strobe and data) and the synchronous 2 KiB data RAM. Grants one access per clock and stalls the core when it loses arbitration. Routes one-cycle-latency read data back to whichever requester issued the read.

## Interface
Parameters:
- ADDR_W, 11, RAM address width (2048 bytes)
- STARVE_LIMIT, 4, consecutive aux denials before aux is forced through (only with fairness enabled); legal range 1..15

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- cpu_req  in  1  core requests a data access this cycle
- cpu_we  in  1  core access is a write
- cpu_addr  in  16  core data address
- cpu_wdata  in  8  core write data
- cpu_rdata  out  8  read data, valid the cycle after a granted core read
- cpu_stall  out  1  core request denied this cycle; core holds request
- aux_req  in  1  aux requests an access; held until aux_gnt
- aux_we  in  1  aux access is a write
- aux_addr  in  ADDR_W  aux RAM address
- aux_wdata  in  8  aux write data
- aux_gnt  out  1  aux access issued to RAM this cycle
- aux_rvalid  out  1  aux read data valid (cycle after aux_gnt for a read)
- aux_rdata  out  8  aux read data
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM registered read data (one-cycle latency)

## Operation
- Owner decided combinationally each cycle. Default: CPU wins whenever cpu_req=1; aux wins when cpu_req=0 and aux_req=1; otherwise idle (mem_we=0, mem_addr holds last value).
- CPU granted: mem_addr=cpu_addr[ADDR_W-1:0], mem_we=cpu_we & in-range, cpu_stall=0.
- CPU out-of-range (cpu_addr ≥ 2^ADDR_W): the access is granted; the write is suppressed; the read returns 0x00 the next cycle.
- Aux granted: mem driven from aux_*, aux_gnt=1 for exactly that cycle; aux may present its next request in the following cycle.
- cpu_stall=1 only in a cycle where cpu_req=1 and aux is granted.
- Read return pipeline: registers rd_owner ∈ {NONE, CPU, AUX} and rd_oor, capturing the cycle's grant. Next cycle:
  - rd_owner=CPU: cpu_rdata = rd_oor ? 0x00 : mem_rdata.
  - rd_owner=AUX: aux_rvalid=1, aux_rdata=mem_rdata.
- Writes generate no return cycle. Back-to-back reads from alternating owners are legal every cycle.
- Reads and writes to the same address are ordered by grant order; a write followed by a read in the next cycle returns the new data (RAM write-first not required; one slot separates them).

## Timing
- Reset values: cpu_stall=0, aux_gnt=0, aux_rvalid=0, cpu_rdata=0x00, aux_rdata=0x00, mem_we=0, mem_addr=0, mem_wdata=0, rd_owner=NONE, starvation counter=0.
- Grant/stall: combinational, same cycle as request. Read latency: 1 cycle after grant for both masters.
- RST asserted mid-operation: a pending aux read is dropped (no aux_rvalid after reset); no mem_we is issued while RST=1.
- Simultaneous cpu_req and aux_req: resolved per Operation and Configuration; never two grants in one cycle.

## Configuration
- AVR_DMEM_ARB_FAIR_EN defined: 4-bit starvation counter increments each cycle aux_req=1 and aux is denied, and clears on aux_gnt or when aux_req=0. When counter == STARVE_LIMIT, aux wins over cpu_req for that cycle (cpu_stall=1) and the counter clears.
- AVR_DMEM_ARB_FAIR_EN undefined: strict CPU priority, no counter; aux may starve indefinitely.

## Structure
- Shared package avr_mem_pkg: owner enum (OWN_NONE, OWN_CPU, OWN_AUX), DMEM_ADDR_W=11, DMEM_SIZE=2048.
- One sub-module: avr_arb_starve_cnt (counter, limit compare, clear), instantiated only under AVR_DMEM_ARB_FAIR_EN.

## Test plan
- CPU write 0x5A to 0x0010, then read 0x0010 with aux idle -> cpu_stall never asserted; cpu_rdata=0x5A one cycle after the read grant.
- aux_req read of 0x0010 while cpu_req=0 -> aux_gnt the same cycle; aux_rvalid=1 with aux_rdata=0x5A next cycle.
- cpu_req held continuously, aux_req=1, fairness on, STARVE_LIMIT=4 -> aux denied 4 cycles, granted in the 5th with cpu_stall=1 that cycle only; fairness off -> aux never granted.
- CPU write 0xFF to 0x0900 (out of range) -> mem_we stays 0; RAM[0x100] unchanged; CPU read of 0x0900 returns 0x00.
- Alternating grants: CPU read 0x0001, aux read 0x0002, CPU read 0x0003 in consecutive cycles -> each datum is returned to the correct master with 1-cycle latency; no cross-delivery.
- RST pulsed the cycle after an aux read grant -> aux_rvalid stays 0; all outputs at reset values during RST.

Source files
------------

// File: rtl/avr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avr_mem_pkg
// Description : Shared definitions for the AVR data-memory subsystem.
//               Provides the read-return owner encoding and the RAM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package avr_mem_pkg;

   localparam int DMEM_ADDR_W = 11;
   localparam int DMEM_SIZE   = 2048;

   // Which master the RAM read data of the current cycle belongs to.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_AUX  = 2'd2
   } owner_e;

endpackage : avr_mem_pkg
`default_nettype wire

// File: rtl/avr_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : avr_arb_starve_cnt
// Description : Auxiliary-master starvation counter. Counts consecutive
//               cycles in which aux is requesting but not granted; when the
//               count reaches STARVE_LIMIT, force_aux tells the arbiter to let
//               aux through for one cycle (the grant then clears the count).
// Ports       : CLK, RST (async, active-high)
//               aux_req   - aux is requesting this cycle
//               aux_gnt   - aux was granted this cycle
//               force_aux - aux must win arbitration this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module avr_arb_starve_cnt
   import avr_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic aux_req,
   input  logic aux_gnt,
   output logic force_aux
);

   logic [3:0] cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= 4'd0;
      end else if (!aux_req || aux_gnt) begin
         cnt <= 4'd0;
      end else if (cnt != 4'hF) begin
         cnt <= cnt + 4'd1;
      end
   end

   assign force_aux = aux_req && (cnt == 4'(STARVE_LIMIT));

endmodule : avr_arb_starve_cnt
`default_nettype wire

// File: rtl/avr_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : avr_dmem_arbiter
// Description : Single-port data-RAM arbiter between the AVR core data port
//               and an auxiliary master (debug/loader/DMA). One access per
//               clock, CPU priority by default, one-cycle read return routed
//               to whichever master issued the read.
// Config      : `define AVR_DMEM_ARB_FAIR_EN to enable the aux starvation
//               counter (aux forced through after STARVE_LIMIT denials).
// Ports       : CLK, RST (async, active-high)
//               cpu_req/we/addr/wdata -> core request; cpu_rdata, cpu_stall
//               aux_req/we/addr/wdata -> aux request; aux_gnt, aux_rvalid,
//               aux_rdata
//               mem_addr/we/wdata     -> RAM; mem_rdata <- RAM (1-cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module avr_dmem_arbiter
   import avr_mem_pkg::*;
#(
   parameter int ADDR_W       = DMEM_ADDR_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [15:0]       cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_stall,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [7:0]        aux_wdata,
   output logic              aux_gnt,
   output logic              aux_rvalid,
   output logic [7:0]        aux_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_chk
      $error("avr_dmem_arbiter: STARVE_LIMIT must be in 1..15");
   end

   logic              force_aux;
   logic              cpu_win;
   logic              aux_win;
   logic              cpu_oor;
   logic [ADDR_W-1:0] last_addr;
   logic [7:0]        last_wdata;
   owner_e            rd_owner;
   logic              rd_oor;

`ifdef AVR_DMEM_ARB_FAIR_EN
   avr_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .CLK       (CLK),
      .RST       (RST),
      .aux_req   (aux_req),
      .aux_gnt   (aux_gnt),
      .force_aux (force_aux)
   );
`else
   assign force_aux = 1'b0;
`endif

   // Any address bit above the RAM window marks the access out of range.
   assign cpu_oor = (cpu_addr >> ADDR_W) != 16'd0;

   // Grant decision; nothing is granted while reset is asserted so that no
   // write can reach the RAM during reset.
   always_comb begin
      cpu_win = 1'b0;
      aux_win = 1'b0;
      if (!RST) begin
         if (aux_req && (force_aux || !cpu_req)) begin
            aux_win = 1'b1;
         end else if (cpu_req) begin
            cpu_win = 1'b1;
         end
      end
   end

   // RAM port mux; when idle the address/data hold their last driven value.
   always_comb begin
      mem_addr  = last_addr;
      mem_wdata = last_wdata;
      mem_we    = 1'b0;
      if (cpu_win) begin
         mem_addr  = cpu_addr[ADDR_W-1:0];
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we && !cpu_oor;
      end else if (aux_win) begin
         mem_addr  = aux_addr;
         mem_wdata = aux_wdata;
         mem_we    = aux_we;
      end
   end

   assign aux_gnt   = aux_win;
   assign cpu_stall = cpu_req && aux_win;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_addr  <= '0;
         last_wdata <= 8'h00;
         rd_owner   <= OWN_NONE;
         rd_oor     <= 1'b0;
      end else begin
         last_addr  <= mem_addr;
         last_wdata <= mem_wdata;
         rd_oor     <= cpu_win && cpu_oor;
         if (cpu_win && !cpu_we) begin
            rd_owner <= OWN_CPU;
         end else if (aux_win && !aux_we) begin
            rd_owner <= OWN_AUX;
         end else begin
            rd_owner <= OWN_NONE;
         end
      end
   end

   // Read return: RAM data is steered to the owner of last cycle's read;
   // out-of-range CPU reads return zero.
   assign cpu_rdata  = (rd_owner == OWN_CPU && !rd_oor) ? mem_rdata : 8'h00;
   assign aux_rvalid = (rd_owner == OWN_AUX);
   assign aux_rdata  = aux_rvalid ? mem_rdata : 8'h00;

endmodule : avr_dmem_arbiter
`default_nettype wire

// File: tb/tb_avr_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_avr_dmem_arbiter
// Description : Self-checking bench for avr_dmem_arbiter with a behavioural
//               2 KiB synchronous RAM, a shadow memory and a read-return
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avr_dmem_arbiter;

   localparam int AW  = 11;
   localparam int LIM = 4;

   logic          CLK;
   logic          RST;
   logic          cpu_req, cpu_we;
   logic [15:0]   cpu_addr;
   logic [7:0]    cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          aux_req, aux_we;
   logic [AW-1:0] aux_addr;
   logic [7:0]    aux_wdata, aux_rdata;
   logic          aux_gnt, aux_rvalid;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [7:0]    mem_wdata, mem_rdata;

   avr_dmem_arbiter #(
      .ADDR_W       (AW),
      .STARVE_LIMIT (LIM)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .aux_req    (aux_req),
      .aux_we     (aux_we),
      .aux_addr   (aux_addr),
      .aux_wdata  (aux_wdata),
      .aux_gnt    (aux_gnt),
      .aux_rvalid (aux_rvalid),
      .aux_rdata  (aux_rdata),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Behavioural synchronous RAM, one-cycle read latency.
   logic [7:0] ram [0:2047];
   always @(posedge CLK) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic          cpu_req;
      logic          cpu_we;
      logic [15:0]   cpu_addr;
      logic [7:0]    cpu_wdata;
      logic          aux_req;
      logic          aux_we;
      logic [AW-1:0] aux_addr;
      logic [7:0]    aux_wdata;
      logic          exp_stall;
      logic          exp_gnt;
   } vec_t;

   typedef struct {
      logic       is_aux;
      logic [7:0] data;
   } ret_t;

   ret_t          sbq[$];
   logic [7:0]    shadow [0:2047];
   logic [AW-1:0] last_addr;
   int            total = 0;
   int            bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic cr, input logic cw, input logic [15:0] ca,
                               input logic [7:0] cd, input logic ar, input logic aw,
                               input logic [AW-1:0] aa, input logic [7:0] ad,
                               input logic es, input logic eg);
      vec_t v;
      v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
      v.aux_req = ar; v.aux_we = aw; v.aux_addr = aa; v.aux_wdata = ad;
      v.exp_stall = es; v.exp_gnt = eg;
      return v;
   endfunction

   function automatic vec_t cpu_wr(input logic [15:0] a, input logic [7:0] d);
      return mk(1, 1, a, d, 0, 0, '0, 8'h00, 0, 0);
   endfunction
   function automatic vec_t cpu_rd(input logic [15:0] a);
      return mk(1, 0, a, 8'h00, 0, 0, '0, 8'h00, 0, 0);
   endfunction
   function automatic vec_t aux_wr(input logic [AW-1:0] a, input logic [7:0] d);
      return mk(0, 0, 16'h0, 8'h00, 1, 1, a, d, 0, 1);
   endfunction
   function automatic vec_t aux_rd(input logic [AW-1:0] a);
      return mk(0, 0, 16'h0, 8'h00, 1, 0, a, 8'h00, 0, 1);
   endfunction
   function automatic vec_t idle();
      return mk(0, 0, 16'h0, 8'h00, 0, 0, '0, 8'h00, 0, 0);
   endfunction

   // One arbitration cycle: drive, check grant/RAM port, record expected
   // read return, clock, then check the return against the scoreboard.
   task automatic cycle(input vec_t v);
      logic          cg, ag, oor, ewe;
      logic [AW-1:0] ea;
      logic [7:0]    ewd;
      ret_t          r;
      cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
      aux_req = v.aux_req; aux_we = v.aux_we; aux_addr = v.aux_addr; aux_wdata = v.aux_wdata;
      #1;
      ag  = v.exp_gnt;
      cg  = v.cpu_req && !v.exp_gnt;
      oor = (v.cpu_addr >= 16'h0800);
      check("cpu_stall", {31'd0, cpu_stall}, {31'd0, v.exp_stall});
      check("aux_gnt", {31'd0, aux_gnt}, {31'd0, v.exp_gnt});
      ea = last_addr; ewe = 1'b0; ewd = 8'h00;
      if (cg) begin
         ea = v.cpu_addr[AW-1:0]; ewe = v.cpu_we && !oor; ewd = v.cpu_wdata;
      end else if (ag) begin
         ea = v.aux_addr; ewe = v.aux_we; ewd = v.aux_wdata;
      end
      check("mem_we", {31'd0, mem_we}, {31'd0, ewe});
      check("mem_addr", {21'd0, mem_addr}, {21'd0, ea});
      if (ewe) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, ewd});
      if (cg && !v.cpu_we) begin
         r.is_aux = 1'b0; r.data = oor ? 8'h00 : shadow[ea]; sbq.push_back(r);
      end
      if (ag && !v.aux_we) begin
         r.is_aux = 1'b1; r.data = shadow[ea]; sbq.push_back(r);
      end
      if (ewe) shadow[ea] = ewd;
      if (cg || ag) last_addr = ea;
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
         r = sbq.pop_front();
         if (r.is_aux) begin
            check("aux_rvalid", {31'd0, aux_rvalid}, 32'd1);
            check("aux_rdata", {24'd0, aux_rdata}, {24'd0, r.data});
         end else begin
            check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, r.data});
            check("aux_rvalid_on_cpu_read", {31'd0, aux_rvalid}, 32'd0);
         end
      end else begin
         check("aux_rvalid_idle", {31'd0, aux_rvalid}, 32'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cpu_stall"}, {31'd0, cpu_stall}, 32'd0);
      check({tag, "_aux_gnt"}, {31'd0, aux_gnt}, 32'd0);
      check({tag, "_aux_rvalid"}, {31'd0, aux_rvalid}, 32'd0);
      check({tag, "_cpu_rdata"}, {24'd0, cpu_rdata}, 32'd0);
      check({tag, "_aux_rdata"}, {24'd0, aux_rdata}, 32'd0);
      check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      check({tag, "_mem_addr"}, {21'd0, mem_addr}, 32'd0);
      check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
   endtask

   vec_t tbl [0:17];

   initial begin
      for (int i = 0; i < 2048; i++) shadow[i] = 8'h00;
      last_addr = '0;

      tbl[0]  = cpu_wr(16'h0010, 8'h5A);
      tbl[1]  = cpu_rd(16'h0010);
      tbl[2]  = idle();
      tbl[3]  = aux_rd(11'h010);
      tbl[4]  = cpu_wr(16'h0900, 8'hFF);
      tbl[5]  = cpu_rd(16'h0100);
      tbl[6]  = cpu_rd(16'h0900);
      tbl[7]  = cpu_rd(16'h0001);
      tbl[8]  = aux_rd(11'h002);
      tbl[9]  = cpu_rd(16'h0003);
      tbl[10] = mk(1, 0, 16'h0004, 8'h00, 1, 1, 11'h005, 8'h66, 0, 0);
      tbl[11] = aux_wr(11'h005, 8'h66);
      tbl[12] = aux_rd(11'h005);
      tbl[13] = cpu_wr(16'h0020, 8'h77);
      tbl[14] = aux_rd(11'h020);
      tbl[15] = cpu_rd(16'h07FF);
      tbl[16] = cpu_rd(16'h0800);
      tbl[17] = idle();

      // Reset with both masters requesting a write: nothing may be granted.
      RST = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hEE;
      aux_req = 1'b1; aux_we = 1'b1; aux_addr = 11'h011; aux_wdata = 8'hEE;
      #2;
      check_reset_outputs("reset");
      @(posedge CLK);
      #1;
      check("reset_mem_we_clk", {31'd0, mem_we}, 32'd0);
      cycle_idle_inputs();
      RST = 1'b0;

      // Preload the locations read later, mixing both masters.
      cycle(cpu_wr(16'h0001, 8'h11));
      cycle(aux_wr(11'h002, 8'h22));
      cycle(cpu_wr(16'h0003, 8'h33));
      cycle(aux_wr(11'h004, 8'h44));
      cycle(cpu_wr(16'h0100, 8'hC3));
      cycle(aux_wr(11'h7FF, 8'h7E));
      cycle(cpu_wr(16'h0030, 8'h30));
      cycle(cpu_wr(16'h0031, 8'h31));

      for (int i = 0; i < 18; i++) cycle(tbl[i]);

      // Continuous contention: CPU reads 0x030, aux wants to read 0x031.
`ifdef AVR_DMEM_ARB_FAIR_EN
      for (int i = 0; i < LIM; i++) cycle(mk(1, 0, 16'h0030, 8'h00, 1, 0, 11'h031, 8'h00, 0, 0));
      cycle(mk(1, 0, 16'h0030, 8'h00, 1, 0, 11'h031, 8'h00, 1, 1));
      cycle(mk(1, 0, 16'h0030, 8'h00, 1, 0, 11'h031, 8'h00, 0, 0));
      cycle(cpu_rd(16'h0030));
`else
      for (int i = 0; i < 3 * LIM; i++) cycle(mk(1, 0, 16'h0030, 8'h00, 1, 0, 11'h031, 8'h00, 0, 0));
      cycle(cpu_rd(16'h0030));
`endif
      cycle(idle());

      // Reset asserted the cycle after an aux read grant: the read is dropped.
      cpu_req = 1'b0; cpu_we = 1'b0;
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 11'h010;
      #1;
      check("pre_reset_aux_gnt", {31'd0, aux_gnt}, 32'd1);
      @(posedge CLK);
      RST = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hEE;
      #1;
      check_reset_outputs("midreset");
      @(posedge CLK);
      #1;
      check("midreset_mem_we_clk", {31'd0, mem_we}, 32'd0);
      check("midreset_aux_rvalid_clk", {31'd0, aux_rvalid}, 32'd0);
      cycle_idle_inputs();
      RST = 1'b0;
      last_addr = '0;
      #1;
      check("post_reset_aux_rvalid", {31'd0, aux_rvalid}, 32'd0);
      @(posedge CLK);
      #1;
      // Location 0x010 must still hold the value written before reset.
      cycle(cpu_rd(16'h0010));
      cycle(aux_rd(11'h010));
      cycle(idle());

      check("scoreboard_empty", sbq.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic cycle_idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h00;
      aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0;   aux_wdata = 8'h00;
   endtask

endmodule : tb_avr_dmem_arbiter
`default_nettype wire
